// File: rtl/fft_addr_gen_pkg.sv
// Shared types, sizes and index helpers for the in-place radix-2 FFT
// address generator.
package fft_addr_gen_pkg;

  // Default transform size: N = 2^R_DEF complex points over two banks.
  localparam int R_DEF   = 5;
  localparam int N       = 1 << R_DEF;
  localparam int HALF    = N / 2;
  localparam int STAGE_W = $clog2(R_DEF);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_READ  = 3'd1,
    ST_WAIT  = 3'd2,
    ST_BF    = 3'd3,
    ST_WRITE = 3'd4
  } state_t;

  // XOR of all index bits; selects the bank that holds the point.
  function automatic logic parity(input logic [31:0] idx);
    return ^idx;
  endfunction

  // Open a zero at bit position s of j: bits below s stay, bits at and
  // above s move up by one. Yields the top operand of butterfly j.
  function automatic logic [31:0] insert_zero(input logic [31:0] j,
                                              input logic [31:0] s);
    logic [31:0] low_mask;
    low_mask = (32'd1 << s) - 32'd1;
    return ((j & ~low_mask) << 1) | (j & low_mask);
  endfunction

endpackage

// File: rtl/fft_bank_map.sv
// Maps a point index to its bank and in-bank address. Adjacent-parity
// indices always land in opposite banks, so a butterfly pair never collides.
module fft_bank_map
  import fft_addr_gen_pkg::*;
#(
  parameter int R = R_DEF
) (
  input  logic [R-1:0] idx,
  output logic         bank,
  output logic [R-2:0] addr
);

  // Bank is the index parity; the address drops the least significant bit.
  always_comb begin
    bank = parity(32'(idx));
    addr = idx[R-1:1];
  end

endmodule

// File: rtl/fft_addr_gen.sv
// In-place radix-2 DIT FFT sequencer for a two-bank memory. Walks every
// butterfly of every stage, driving read addresses, the butterfly strobe,
// the twiddle exponent and the write-back to the same locations.
//
//   state    | meaning
//   ---------+-------------------------------------------------------
//   ST_IDLE  | waiting for i_start; counters parked at s = 0, j = 0
//   ST_READ  | operand addresses presented to both banks
//   ST_WAIT  | bank read data valid at butterfly inputs (o_bf_valid)
//   ST_BF    | butterfly datapath latency, BF_LAT cycles (skipped if 0)
//   ST_WRITE | results written back to the same addresses (o_w_en)
//
// All outputs are registered: the output logic works from the next state
// and next counter values so each output lines up with its state cycle.
module fft_addr_gen
  import fft_addr_gen_pkg::*;
#(
  parameter int R      = R_DEF,
  parameter int BF_LAT = 2
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_start,
  output logic [R-2:0]         o_addr0,
  output logic [R-2:0]         o_addr1,
  output logic                 o_w_en,
  output logic                 o_swap,
  output logic                 o_bf_valid,
  output logic [R-2:0]         o_tw_addr,
  output logic [$clog2(R)-1:0] o_stage,
  output logic                 o_busy,
  output logic                 o_done
);

  localparam int AW = R - 1;
  localparam int SW = $clog2(R);
  localparam int BW = (BF_LAT > 1) ? $clog2(BF_LAT) : 1;

  localparam logic [AW-1:0] J_LAST  = AW'((1 << AW) - 1);
  localparam logic [SW-1:0] S_LAST  = SW'(R - 1);
  // Down-counter start value; the BF state exits when it reaches zero.
  localparam logic [BW-1:0] BF_LOAD = (BF_LAT > 0) ? BW'(BF_LAT - 1) : '0;

  state_t        state_q, state_n;
  logic [SW-1:0] s_q, s_n;
  logic [AW-1:0] j_q, j_n;
  logic [BW-1:0] bf_cnt_q;

  logic [R-1:0]  top_idx, bot_idx;
  logic          top_bank, bot_bank;
  logic [AW-1:0] top_addr, bot_addr;
  logic [AW-1:0] tw_n;

  logic          busy_d, bf_valid_d, w_en_d, done_d, swap_d;
  logic [AW-1:0] addr0_d, addr1_d, tw_d;
  logic [SW-1:0] stage_d;

  // State register, butterfly/stage counters and BF latency timer.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q  <= ST_IDLE;
      s_q      <= '0;
      j_q      <= '0;
      bf_cnt_q <= '0;
    end else begin
      state_q <= state_n;
      s_q     <= s_n;
      j_q     <= j_n;
      if (state_q == ST_WAIT) begin
        bf_cnt_q <= BF_LOAD;
      end else if (state_q == ST_BF && bf_cnt_q != '0) begin
        bf_cnt_q <= bf_cnt_q - 1'b1;
      end
    end
  end

  // Next-state logic for the butterfly sequence.
  always_comb begin
    state_n = state_q;
    case (state_q)
      ST_IDLE:  if (i_start) state_n = ST_READ;
      ST_READ:  state_n = ST_WAIT;
      ST_WAIT:  state_n = (BF_LAT == 0) ? ST_WRITE : ST_BF;
      ST_BF:    if (bf_cnt_q == '0) state_n = ST_WRITE;
      ST_WRITE: state_n = (s_q == S_LAST && j_q == J_LAST) ? ST_IDLE : ST_READ;
      default:  state_n = ST_IDLE;
    endcase
  end

  // Counters advance once per butterfly, at the end of WRITE. The final
  // butterfly wraps both back to zero, which is also the idle value.
  always_comb begin
    s_n = s_q;
    j_n = j_q;
    if (state_q == ST_WRITE) begin
      if (j_q == J_LAST) begin
        j_n = '0;
        s_n = (s_q == S_LAST) ? '0 : s_q + 1'b1;
      end else begin
        j_n = j_q + 1'b1;
      end
    end
  end

  // Operand indices and twiddle exponent for the butterfly about to run.
  always_comb begin
    top_idx = R'(insert_zero(32'(j_n), 32'(s_n)));
    bot_idx = top_idx | R'(32'd1 << s_n);
    tw_n    = AW'((32'(j_n) & ((32'd1 << s_n) - 32'd1)) << (32'(AW) - 32'(s_n)));
  end

  fft_bank_map #(.R(R)) u_map_top (
    .idx  (top_idx),
    .bank (top_bank),
    .addr (top_addr)
  );

  fft_bank_map #(.R(R)) u_map_bot (
    .idx  (bot_idx),
    .bank (bot_bank),
    .addr (bot_addr)
  );

  // Output decode from the next state; addresses are zeroed outside a run.
  always_comb begin
    busy_d     = 1'b0;
    bf_valid_d = 1'b0;
    w_en_d     = 1'b0;
    swap_d     = 1'b0;
    addr0_d    = '0;
    addr1_d    = '0;
    tw_d       = '0;
    stage_d    = '0;
    case (state_n)
      ST_READ, ST_BF: busy_d = 1'b1;
      ST_WAIT: begin
        busy_d     = 1'b1;
        bf_valid_d = 1'b1;
      end
      ST_WRITE: begin
        busy_d = 1'b1;
        w_en_d = 1'b1;
      end
      default: busy_d = 1'b0;
    endcase
    if (busy_d) begin
      swap_d  = top_bank;
      addr0_d = top_bank ? bot_addr : top_addr;
      addr1_d = bot_bank ? bot_addr : top_addr;
      tw_d    = tw_n;
      stage_d = s_n;
    end
    done_d = (state_q == ST_WRITE) && (state_n == ST_IDLE);
  end

  // Output registers.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_addr0    <= '0;
      o_addr1    <= '0;
      o_w_en     <= 1'b0;
      o_swap     <= 1'b0;
      o_bf_valid <= 1'b0;
      o_tw_addr  <= '0;
      o_stage    <= '0;
      o_busy     <= 1'b0;
      o_done     <= 1'b0;
    end else begin
      o_addr0    <= addr0_d;
      o_addr1    <= addr1_d;
      o_w_en     <= w_en_d;
      o_swap     <= swap_d;
      o_bf_valid <= bf_valid_d;
      o_tw_addr  <= tw_d;
      o_stage    <= stage_d;
      o_busy     <= busy_d;
      o_done     <= done_d;
    end
  end

endmodule

// File: tb/tb_fft_addr_gen.sv
// Bench for fft_addr_gen: a reference schedule of butterflies is queued when
// a run is started, and a negedge monitor compares the DUT against it while
// also running behavioural banks and a butterfly model to check the spectrum.
module tb_fft_addr_gen;
  import fft_addr_gen_pkg::*;

  localparam int  RR   = R_DEF;
  localparam int  L    = 2;
  localparam int  NP   = N;
  localparam int  HP   = HALF;
  localparam int  AW   = RR - 1;
  localparam int  SW   = STAGE_W;
  localparam int  RUNC = HP * RR * (3 + L);
  localparam int  MAXC = 4096;
  localparam real PI   = 3.14159265358979323846;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [AW-1:0] addr0, addr1, tw;
  logic          w_en, swap, bf_valid, busy, done;
  logic [SW-1:0] stage;

  fft_addr_gen #(.R(RR), .BF_LAT(L)) dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_start    (start),
    .o_addr0    (addr0),
    .o_addr1    (addr1),
    .o_w_en     (w_en),
    .o_swap     (swap),
    .o_bf_valid (bf_valid),
    .o_tw_addr  (tw),
    .o_stage    (stage),
    .o_busy     (busy),
    .o_done     (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int rd_cyc;
    int wr_cyc;
    int a0;
    int a1;
    int sw;
    int tw;
    int st;
  } bfly_t;

  bfly_t exp_q[$];
  bit    exp_busy [MAXC];
  bit    exp_done [MAXC];
  int    wr_cnt   [RR][NP];

  real m_re [2][HP];
  real m_im [2][HP];
  real x_re [NP];
  real x_im [NP];
  real e_re [NP];
  real e_im [NP];

  int  checks = 0;
  int  passes = 0;
  int  ncyc   = 0;

  function automatic void chk(string name, longint act, longint exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, ncyc);
  endfunction

  function automatic void chk_real(string name, real act, real exp);
    real d;
    checks++;
    d = act - exp;
    if (d < 0.0) d = -d;
    if (d < 1.0e-6) passes++;
    else $display("FAIL %s: got %f expected %f", name, act, exp);
  endfunction

  function automatic int par(int v);
    return $countones(v) & 1;
  endfunction

  function automatic int bitrev(int v);
    int r;
    r = 0;
    for (int b = 0; b < RR; b++) if (((v >> b) & 1) == 1) r |= 1 << (RR - 1 - b);
    return r;
  endfunction

  // Reference schedule: stage-major, butterfly-minor, fixed cycle cost each.
  task automatic push_run(input int sref);
    bfly_t e;
    int b, span, top, bot;
    b = 0;
    for (int s = 0; s < RR; s++) begin
      for (int j = 0; j < HP; j++) begin
        span     = 1 << s;
        top      = (j / span) * 2 * span + (j % span);
        bot      = top + span;
        e.rd_cyc = sref + 1 + b * (3 + L);
        e.wr_cyc = e.rd_cyc + 2 + L;
        e.sw     = par(top);
        e.a0     = (e.sw == 0) ? top / 2 : bot / 2;
        e.a1     = (e.sw == 0) ? bot / 2 : top / 2;
        e.tw     = (j % span) * (HP / span);
        e.st     = s;
        exp_q.push_back(e);
        b++;
      end
    end
    for (int c = 1; c <= RUNC; c++) exp_busy[sref + c] = 1'b1;
    exp_done[sref + RUNC + 1] = 1'b1;
  endtask

  // Monitor state.
  int  i0, i1, tp, bt;
  real a_re, a_im, b_re, b_im, w_re, w_im, t_re, t_im;
  real pt_re, pt_im, pb_re, pb_im;
  bit  exp_bfv, exp_wen;

  always @(negedge clk) begin
    ncyc++;
    if (ncyc < MAXC) begin
      chk("busy", busy, exp_busy[ncyc]);
      chk("done", done, exp_done[ncyc]);
    end
    exp_bfv = (exp_q.size() > 0) && (ncyc == exp_q[0].rd_cyc + 1);
    exp_wen = (exp_q.size() > 0) && (ncyc == exp_q[0].wr_cyc);
    chk("bf_valid", bf_valid, exp_bfv);
    chk("w_en", w_en, exp_wen);
    if (busy && exp_q.size() > 0 && ncyc >= exp_q[0].rd_cyc) begin
      chk("addr0", addr0, exp_q[0].a0);
      chk("addr1", addr1, exp_q[0].a1);
      chk("swap", swap, exp_q[0].sw);
      chk("tw_addr", tw, exp_q[0].tw);
      chk("stage", stage, exp_q[0].st);
    end
    i0 = 2 * int'(addr0) + par(int'(addr0));
    i1 = 2 * int'(addr1) + 1 - par(int'(addr1));
    tp = swap ? i1 : i0;
    bt = swap ? i0 : i1;
    if (bf_valid) begin
      a_re = swap ? m_re[1][addr1] : m_re[0][addr0];
      a_im = swap ? m_im[1][addr1] : m_im[0][addr0];
      b_re = swap ? m_re[0][addr0] : m_re[1][addr1];
      b_im = swap ? m_im[0][addr0] : m_im[1][addr1];
      w_re = $cos(2.0 * PI * real'(tw) / real'(NP));
      w_im = -$sin(2.0 * PI * real'(tw) / real'(NP));
      t_re = b_re * w_re - b_im * w_im;
      t_im = b_re * w_im + b_im * w_re;
      pt_re = a_re + t_re;
      pt_im = a_im + t_im;
      pb_re = a_re - t_re;
      pb_im = a_im - t_im;
    end
    if (w_en) begin
      chk("pair_bottom", bt, tp | (1 << stage));
      chk("pair_top_bit", (tp >> stage) & 1, 0);
      if (int'(stage) < RR) begin
        wr_cnt[stage][tp]++;
        wr_cnt[stage][bt]++;
      end
      if (swap) begin
        m_re[1][addr1] = pt_re; m_im[1][addr1] = pt_im;
        m_re[0][addr0] = pb_re; m_im[0][addr0] = pb_im;
      end else begin
        m_re[0][addr0] = pt_re; m_im[0][addr0] = pt_im;
        m_re[1][addr1] = pb_re; m_im[1][addr1] = pb_im;
      end
    end
    if (exp_wen) void'(exp_q.pop_front());
  end

  // Stimulus helpers: all driving happens 2 time units after a rising edge.
  task automatic wait_ncyc(input int target);
    int guard;
    guard = 0;
    while (ncyc < target && guard < 20000) begin
      @(posedge clk); #2;
      guard++;
    end
    if (ncyc < target) chk("wait_timeout", ncyc, target);
  endtask

  task automatic load_input(input bit impulse);
    int idx;
    real ang;
    for (int n = 0; n < NP; n++) begin
      x_re[n] = impulse ? ((n == 0) ? 1.0 : 0.0) : real'(int'($urandom_range(0, 200)) - 100);
      x_im[n] = impulse ? 0.0 : real'(int'($urandom_range(0, 200)) - 100);
      idx = bitrev(n);
      m_re[par(idx)][idx / 2] = x_re[n];
      m_im[par(idx)][idx / 2] = x_im[n];
    end
    for (int k = 0; k < NP; k++) begin
      e_re[k] = 0.0;
      e_im[k] = 0.0;
      for (int n = 0; n < NP; n++) begin
        ang = 2.0 * PI * real'(n * k) / real'(NP);
        e_re[k] += x_re[n] * $cos(ang) + x_im[n] * $sin(ang);
        e_im[k] += x_im[n] * $cos(ang) - x_re[n] * $sin(ang);
      end
    end
  endtask

  task automatic issue_start(output int sref);
    start = 1'b1;
    sref  = ncyc + 1;
    for (int s = 0; s < RR; s++) for (int i = 0; i < NP; i++) wr_cnt[s][i] = 0;
    push_run(sref);
    @(posedge clk); #2;
    start = 1'b0;
  endtask

  task automatic check_run(input string tag);
    int once;
    for (int s = 0; s < RR; s++) begin
      once = 0;
      for (int i = 0; i < NP; i++) if (wr_cnt[s][i] == 1) once++;
      chk({tag, "_written_once"}, once, NP);
    end
    for (int k = 0; k < NP; k++) begin
      chk_real({tag, "_re"}, m_re[par(k)][k / 2], e_re[k]);
      chk_real({tag, "_im"}, m_im[par(k)][k / 2], e_im[k]);
    end
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_addr0"}, addr0, 0);
    chk({tag, "_addr1"}, addr1, 0);
    chk({tag, "_w_en"}, w_en, 0);
    chk({tag, "_swap"}, swap, 0);
    chk({tag, "_bf_valid"}, bf_valid, 0);
    chk({tag, "_tw"}, tw, 0);
    chk({tag, "_stage"}, stage, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
  endtask

  int sa, sb, sc, sd;

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    check_all_zero("reset");
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    check_all_zero("idle");

    // Run A: impulse, spot checks, ignored start at cycle 50.
    load_input(1'b1);
    issue_start(sa);
    wait_ncyc(sa + 0);
    chk("first_addr0", addr0, 0);
    chk("first_addr1", addr1, 0);
    chk("first_swap", swap, 0);
    chk("first_tw", tw, 0);
    chk("first_stage", stage, 0);
    chk("first_busy", busy, 1);
    wait_ncyc(sa + 1);
    chk("first_bf_valid", bf_valid, 1);
    wait_ncyc(sa + 4);
    chk("first_w_en", w_en, 1);
    wait_ncyc(sa + 49);
    start = 1'b1;
    @(posedge clk); #2;
    start = 1'b0;
    wait_ncyc(sa + 185);
    chk("mid_addr0", addr0, 4);
    chk("mid_addr1", addr1, 6);
    chk("mid_swap", swap, 0);
    chk("mid_tw", tw, 4);
    chk("mid_stage", stage, 2);
    wait_ncyc(sa + 400);
    chk("done_cycle_401", done, 1);
    chk("idle_in_done_cycle", busy, 0);
    check_run("impulse");

    // Run B: started in run A's done cycle, random data.
    load_input(1'b0);
    issue_start(sb);
    wait_ncyc(sb + 400);
    check_run("random_b");
    repeat (3) @(posedge clk);
    #2;

    // Run C: aborted by an asynchronous reset in cycle 123.
    issue_start(sc);
    wait_ncyc(sc + 122);
    rst = 1'b1;
    #1;
    check_all_zero("async_reset");
    exp_q.delete();
    for (int c = ncyc + 1; c < MAXC; c++) begin
      exp_busy[c] = 1'b0;
      exp_done[c] = 1'b0;
    end
    @(posedge clk); #2;
    @(posedge clk); #2;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #2;

    // Run D: fresh run after reset, random data.
    load_input(1'b0);
    issue_start(sd);
    wait_ncyc(sd + 400);
    check_run("random_d");
    repeat (3) @(posedge clk);
    #2;

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", passes, checks);
    $fatal(1);
  end

endmodule
